// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial adder/subtractor:
//   state_t   - controller state encoding (IDLE / RUN / DONE)
//   NIBBLE_W  - width of the shared adder slice
//   clog2     - ceiling log2 used to size the nibble index counter
// ---------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int NIBBLE_W = 4;

   // Ceiling log2, clamped to at least 1 so a counter is never zero bits wide.
   function automatic int clog2(input int v);
      int r;
      int p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p * 2;
         r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// ---------------------------------------------------------------------------
// add4_slice
// Combinational 4-bit ripple-carry adder: {o_cout, o_s} = i_a + i_b + i_cin.
// Ports:
//   i_a, i_b  4-bit addends
//   i_cin     carry in
//   o_s       4-bit sum
//   o_cout    carry out
// ---------------------------------------------------------------------------
module add4_slice
   import nibble_serial_adder_ctrl_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_s,
   output logic                o_cout
);

   logic [NIBBLE_W:0] w_full;

   assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};
   assign o_s    = w_full[NIBBLE_W-1:0];
   assign o_cout = w_full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit adder slice,
// stepping LSB nibble first with a registered carry between steps.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (aborts any operation)
//   start  operation request, sampled only while idle
//   sub    0: a+b+cin   1: a-b-cin
//   a, b   WIDTH-bit operands, latched when start is accepted
//   cin    carry-in (add) / borrow-in (sub)
//   busy   high while running and during the done cycle
//   done   one-cycle pulse; sum/cout/ovf valid from here until next start
//   sum    WIDTH-bit result
//   cout   carry out of the MSB (sub: 1 = no borrow)
//   ovf    two's-complement signed overflow
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = clog2(NIB);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_beff;
   logic [WIDTH-1:0]    r_sum;
   logic                r_cout;
   logic                r_ovf;

   logic [NIBBLE_W-1:0] w_a_nib;
   logic [NIBBLE_W-1:0] w_b_nib;
   logic [NIBBLE_W-1:0] w_s;
   logic                w_c;
   logic                w_last;
   logic [WIDTH-1:0]    w_sum_nxt;

   assign w_last = (r_idx == IDX_W'(NIB - 1));

   // Select the current nibble of each operand and splice the slice result
   // back into the matching nibble of the running sum.
   always_comb begin
      w_a_nib   = '0;
      w_b_nib   = '0;
      w_sum_nxt = r_sum;
      for (int k = 0; k < NIB; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
            w_b_nib = r_beff[k*NIBBLE_W +: NIBBLE_W];
            w_sum_nxt[k*NIBBLE_W +: NIBBLE_W] = w_s;
         end
      end
   end

   add4_slice u_slice (
      .i_a    (w_a_nib),
      .i_b    (w_b_nib),
      .i_cin  (r_carry),
      .o_s    (w_s),
      .o_cout (w_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, nibble stepping, final flags
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  // Subtraction is a + ~b + ~borrow, so invert B and the carry-in.
                  r_beff  <= b ^ {WIDTH{sub}};
                  r_carry <= cin ^ sub;
                  r_sum   <= '0;
                  r_idx   <= '0;
               end
            end
            ST_RUN: begin
               r_sum   <= w_sum_nxt;
               r_carry <= w_c;
               if (w_last) begin
                  r_cout <= w_c;
                  r_ovf  <= (r_a[WIDTH-1] == r_beff[WIDTH-1]) &&
                            (w_s[NIBBLE_W-1] != r_a[WIDTH-1]);
                  r_idx  <= '0;
               end else begin
                  r_idx  <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Self-checking bench: operation-level reference model plus directed and
// randomized stimulus for the nibble-serial adder/subtractor (WIDTH=16).
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

   localparam int W   = 16;
   localparam int NIB = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // m_phase: 0 = idle, 1..NIB = cycles since accept while running,
   // NIB+1 = the done cycle.
   int           m_phase = 0;
   logic [W-1:0] e_sum   = '0;
   logic         e_cout  = 1'b0;
   logic         e_ovf   = 1'b0;
   logic [W-1:0] p_sum;
   logic         p_cout;
   logic         p_ovf;

   task automatic model_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                           input logic tc, input logic ts,
                           output logic [W-1:0] rs, output logic rc, output logic ro);
      logic [W:0] full;
      longint     sa, sb, tr;
      sa = longint'($signed(ta));
      sb = longint'($signed(tb_));
      if (!ts) begin
         full = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
         rs   = full[W-1:0];
         rc   = full[W];
         tr   = sa + sb + longint'(tc);
      end else begin
         rs   = ta - tb_ - {{(W-1){1'b0}}, tc};
         rc   = ({1'b0, ta} >= ({1'b0, tb_} + {{W{1'b0}}, tc}));
         tr   = sa - sb - longint'(tc);
      end
      ro = (tr > 64'sd32767) || (tr < -64'sd32768);
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         e_sum   = '0;
         e_cout  = 1'b0;
         e_ovf   = 1'b0;
      end else if (m_phase == 0) begin
         if (start) begin
            model_op(a, b, cin, sub, p_sum, p_cout, p_ovf);
            m_phase = 1;
         end
      end else if (m_phase == NIB + 1) begin
         m_phase = 0;
      end else begin
         m_phase = m_phase + 1;
         if (m_phase == NIB + 1) begin
            e_sum  = p_sum;
            e_cout = p_cout;
            e_ovf  = p_ovf;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, (m_phase != 0));
         chk("done", done, (m_phase == NIB + 1));
         if (m_phase == 0 || m_phase == NIB + 1) begin
            chk("sum", sum, e_sum);
            chk("cout", cout, e_cout);
            chk("ovf", ovf, e_ovf);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts,
                         input logic [W-1:0] xs, input logic xc, input logic xo);
      int n;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (!done && n < 20) begin
         chk({nm, " busy"}, busy, 1'b1);
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, n, 5);
      chk({nm, " busy at done"}, busy, 1'b1);
      chk({nm, " sum"}, sum, xs);
      chk({nm, " cout"}, cout, xc);
      chk({nm, " ovf"}, ovf, xo);
      chk({nm, " model sum"}, e_sum, xs);
      chk({nm, " model cout"}, e_cout, xc);
      chk({nm, " model ovf"}, e_ovf, xo);
      @(negedge clk);
      chk({nm, " busy after"}, busy, 1'b0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return W'($urandom);
      endcase
   endfunction

   // ---------------- main stimulus ----------------
   initial begin
      int dcount;
      int t, last, cnt, n;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset sum", sum, 16'h0000);
      chk("reset cout", cout, 1'b0);
      chk("reset ovf", ovf, 1'b0);
      chk_en = 1'b1;

      run_op("add ffff+1",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add 7fff+1",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("add 1234+4321+1", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
      run_op("sub 5-7",         16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub 8000-1",      16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub 0-0-1",       16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      // Inputs and start toggled while running must not disturb the result.
      @(negedge clk);
      a = 16'h0F0F; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) begin
            dcount++;
            chk("latched sum", sum, 16'h2020);
            chk("latched cout", cout, 1'b0);
         end
         if (i < 4) begin
            start = 1'b1;
            a = W'($urandom); b = W'($urandom);
            sub = ~sub; cin = ~cin;
         end else begin
            start = 1'b0;
         end
      end
      chk("single done pulse", dcount, 1);

      // Reset at the second RUN edge aborts the operation.
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", busy, 1'b0);
      chk("abort done", done, 1'b0);
      chk("abort sum", sum, 16'h0000);
      dcount = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("abort no done", dcount, 0);
      run_op("after abort", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

      // start held high: a new operation every 6 cycles.
      @(negedge clk);
      a = 16'hABCD; b = 16'h1234; cin = 1'b0; sub = 1'b1; start = 1'b1;
      t = 0; last = -1; cnt = 0;
      while (cnt < 3 && t < 40) begin
         @(negedge clk);
         t++;
         if (done) begin
            if (last >= 0) chk("b2b period", t - last, 6);
            chk("b2b sum", sum, 16'h9999);
            last = t;
            cnt++;
         end
      end
      chk("b2b count", cnt, 3);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized operations against the model.
      for (int op = 0; op < 300; op++) begin
         @(negedge clk);
         a = pick(); b = pick();
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         start = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
            start = 1'($urandom_range(0, 1));
            a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         end while (!done && n < 20);
         chk("random done seen", done, 1'b1);
         start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle wide adder/subtractor built around a single shared 4-bit ripple-carry adder slice. The controller latches WIDTH-bit operands and steps the slice once per clock over each nibble, LSB first. A registered carry links successive nibbles. The block sits beside the combinational adders as the area-saving sequenced alternative for wide operands, with a start/busy/done handshake.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, derived (localparam): number of nibble steps.

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
sub    input   1      0 = a+b+cin, 1 = a-b-cin
a      input   WIDTH  operand A
b      input   WIDTH  operand B
cin    input   1      carry-in (add) / borrow-in (sub)
busy   output  1      high in RUN and DONE
done   output  1      one-cycle pulse; results valid
sum    output  WIDTH  result
cout   output  1      carry out of MSB (sub: 1 = no borrow)
ovf    output  1      two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, nibble index=0, carry reg=0, sum=0, cout=0, ovf=0, busy=0, done=0. Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at clock edge E0:
  - latch A=a, Beff=b XOR {WIDTH{sub}};
  - carry reg = cin XOR sub;
  - sum=0, index=0;
  - go to RUN.
- IDLE, start=0: outputs hold their previous values.
- RUN, each edge:
  - slice computes {c, s} = A[4i+3:4i] + Beff[4i+3:4i] + carry;
  - sum[4i+3:4i] <= s; carry <= c; i <= i+1.
  - At i = NIB-1: cout <= c; ovf <= (A[MSB] == Beff[MSB]) && (s[3] != A[MSB]); go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then return to IDLE.
- Latency: done is high in the cycle after edge E_NIB, i.e. NIB+1 edges after start (WIDTH=16: 5).
- sum, cout and ovf are stable from done until the next accepted start.
- start is ignored in RUN and DONE. No queuing. Latched operands are unaffected by input changes after E0.
- done and busy are decoded from registered state only; there are no combinational paths from inputs to outputs.
- Subtraction:
  - result = a - b - cin mod 2^WIDTH;
  - cout=1 when a >= b+cin (unsigned);
  - ovf uses the same formula with Beff.
- Index counter width is clog2(NIB). The counter never exceeds NIB-1 and has no wrap path.

Decomposition:
- Shared package: state encoding enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), NIBBLE_W=4 constant, and a clog2 helper function.
- Sub-module: add4_slice, a combinational 4-bit a+b+cin with carry out. It is instantiated once, and the controller muxes nibble i into it.

Test Plan:
- WIDTH=16, add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. done exactly 5 edges after start, busy high for cycles 1-5.
- add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also add 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- sub 0x0005 - 0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Also sub 0x8000 - 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Pulse start again and change a/b during RUN -> ignored; result matches the operands latched at E0. Exactly one done pulse.
- Assert rst for 1 cycle at the 2nd RUN edge -> state IDLE, sum=0, busy=0, and no done follows. A new start afterwards completes normally.
- Back-to-back: start held high continuously -> a new operation is accepted on the first IDLE cycle after DONE, so done recurs every 6 cycles.
